dmux16_slot_buffer: RTL and testbench

//   Registered, flow-controlled 1-to-2 demultiplexer stage, placed directly downstream of DMux16 routing.

---
 rtl/dmux16_slot_buffer_pkg.sv | 24 ++
 rtl/dmux16_slot_buffer_slot_reg16.sv | 61 ++++++
 rtl/dmux16_slot_buffer.sv | 88 ++++++++
 tb/tb_dmux16_slot_buffer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmux16_slot_buffer_pkg.sv
// ============================================================================
// Module : dmux16_slot_buffer_pkg
// Brief  : Shared widths, channel encoding and slot state type for the
//          dmux16 slot buffer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dmux16_slot_buffer_pkg;

    localparam int DMUX16_WIDTH     = 16;
    localparam int DMUX16_CNT_WIDTH = 8;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

`default_nettype wire

// File: rtl/dmux16_slot_buffer_slot_reg16.sv
// ============================================================================
// Module : slot_reg16
// Brief  : One-entry valid/ready register slot with an async reset.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module slot_reg16
    import dmux16_slot_buffer_pkg::*;
#(
    parameter int WIDTH = DMUX16_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             drained
);

    slot_state_e      r_state;
    slot_state_e      w_next_state;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            SLOT_EMPTY: if (wr_en) w_next_state = SLOT_FULL;
            SLOT_FULL:  if (drained && !wr_en) w_next_state = SLOT_EMPTY;
            default:    w_next_state = SLOT_EMPTY;
        endcase
    end

    // A write always wins: a same-edge drain and write leaves the new word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
        end else if (wr_en) begin
            r_data <= wr_data;
        end else if (drained) begin
            r_data <= '0;
        end
    end

    assign valid   = (r_state == SLOT_FULL);
    assign drained = valid & rd_ready;
    assign data    = valid ? r_data : '0;

endmodule

`default_nettype wire

// File: rtl/dmux16_slot_buffer.sv
// ============================================================================
// Module : dmux16_slot_buffer
// Brief  : Registered 1-to-2 demux stage with two independently drained
//          one-entry slots and saturating per-channel delivery counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dmux16_slot_buffer
    import dmux16_slot_buffer_pkg::*;
#(
    parameter int WIDTH     = DMUX16_WIDTH,
    parameter int CNT_WIDTH = DMUX16_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     a_data,
    output logic                 a_valid,
    input  logic                 a_ready,
    output logic [WIDTH-1:0]     b_data,
    output logic                 b_valid,
    input  logic                 b_ready,
    output logic [CNT_WIDTH-1:0] a_count,
    output logic [CNT_WIDTH-1:0] b_count
);

    logic                 w_accept;
    logic                 w_wr_a;
    logic                 w_wr_b;
    logic                 w_a_drained;
    logic                 w_b_drained;
    logic [CNT_WIDTH-1:0] r_a_count;
    logic [CNT_WIDTH-1:0] r_b_count;

    // Ready looks through to the selected consumer so a full slot can be
    // refilled on the same edge it drains.
    assign in_ready = !reset & ((in_sel == CH_B) ? (!b_valid | b_ready)
                                                 : (!a_valid | a_ready));
    assign w_accept = in_valid & in_ready;
    assign w_wr_a   = w_accept & (in_sel == CH_A);
    assign w_wr_b   = w_accept & (in_sel == CH_B);

    slot_reg16 #(.WIDTH(WIDTH)) u_slot_a (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (w_wr_a),
        .wr_data  (in_data),
        .rd_ready (a_ready),
        .valid    (a_valid),
        .data     (a_data),
        .drained  (w_a_drained)
    );

    slot_reg16 #(.WIDTH(WIDTH)) u_slot_b (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (w_wr_b),
        .wr_data  (in_data),
        .rd_ready (b_ready),
        .valid    (b_valid),
        .data     (b_data),
        .drained  (w_b_drained)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_count <= '0;
            r_b_count <= '0;
        end else begin
            if (w_a_drained && (r_a_count != {CNT_WIDTH{1'b1}})) begin
                r_a_count <= r_a_count + 1'b1;
            end
            if (w_b_drained && (r_b_count != {CNT_WIDTH{1'b1}})) begin
                r_b_count <= r_b_count + 1'b1;
            end
        end
    end

    assign a_count = r_a_count;
    assign b_count = r_b_count;

endmodule

`default_nettype wire

// File: tb/tb_dmux16_slot_buffer.sv
// ============================================================================
// Module : tb_dmux16_slot_buffer
// Brief  : Self-checking bench: vector table, directed corner sequences and a
//          randomized run against a slot/queue reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_dmux16_slot_buffer;

    logic        clk;
    logic        reset;
    logic [15:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_data;
    logic        a_valid;
    logic        a_ready;
    logic [15:0] b_data;
    logic        b_valid;
    logic        b_ready;
    logic [7:0]  a_count;
    logic [7:0]  b_count;

    int total = 0;
    int bad   = 0;

    dmux16_slot_buffer #(.WIDTH(16), .CNT_WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        s;
        logic [15:0] d;
        logic        ar;
        logic        br;
        logic        er;
        logic        eav;
        logic [15:0] ead;
        logic        ebv;
        logic [15:0] ebd;
        logic [7:0]  eac;
        logic [7:0]  ebc;
    } vec_t;

    vec_t tbl[8];

    // Reference model: contents of each output slot plus delivered counts.
    logic        m_full[2];
    logic [15:0] m_word[2];
    int          m_cnt[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [15:0] d,
                         input logic ar, input logic br);
        @(negedge clk);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
        #1;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_full[c] = 1'b0;
            m_word[c] = 16'h0;
            m_cnt[c]  = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset    = 1'b1;
        in_data  = 16'h0;
        in_sel   = 1'b0;
        in_valid = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;

        //               v  s  d         ar br  er av ad        bv bd        ac    bc
        tbl[0] = '{1'b1, 1'b0, 16'h091E, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'd0, 8'd0};
        tbl[1] = '{1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 16'h091E, 1'b0, 16'h0000, 8'd0, 8'd0};
        tbl[2] = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 16'h091E, 1'b0, 16'h0000, 8'd0, 8'd0};
        tbl[3] = '{1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b1, 16'h091E, 1'b0, 16'h0000, 8'd0, 8'd0};
        tbl[4] = '{1'b1, 1'b0, 16'hAAAA, 1'b1, 1'b0, 1'b1, 1'b1, 16'h091E, 1'b1, 16'hBEEF, 8'd0, 8'd0};
        tbl[5] = '{1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b1, 16'hBEEF, 8'd1, 8'd0};
        tbl[6] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'hAAAA, 1'b1, 16'hBEEF, 8'd1, 8'd0};
        tbl[7] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'd2, 8'd1};

        // Outputs while reset is held.
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_a_valid",  a_valid,  0);
        chk("rst_b_valid",  b_valid,  0);
        chk("rst_a_data",   a_data,   0);
        chk("rst_counts",   {a_count, b_count}, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].ar, tbl[i].br);
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].er);
            chk($sformatf("tbl%0d_a_valid", i),  a_valid,  tbl[i].eav);
            chk($sformatf("tbl%0d_a_data", i),   a_data,   tbl[i].ead);
            chk($sformatf("tbl%0d_b_valid", i),  b_valid,  tbl[i].ebv);
            chk($sformatf("tbl%0d_b_data", i),   b_data,   tbl[i].ebd);
            chk($sformatf("tbl%0d_a_count", i),  a_count,  tbl[i].eac);
            chk($sformatf("tbl%0d_b_count", i),  b_count,  tbl[i].ebc);
        end

        // Backpressure: A held stable for five blocked cycles.
        drive(1'b1, 1'b0, 16'h091E, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 16'h4321 + 16'(i), 1'b0, 1'b0);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_a_data",   a_data,   16'h091E);
        end
        drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("bp_drain_count", a_count, 3);

        // Asynchronous reset mid-stream with A full.
        drive(1'b1, 1'b0, 16'h7777, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("mid_a_valid_pre", a_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_a_valid", a_valid,  0);
        chk("mid_rst_a_data",  a_data,   0);
        chk("mid_rst_a_count", a_count,  0);
        chk("mid_rst_ready",   in_ready, 0);
        @(negedge clk);
        reset = 1'b0;

        // Streaming eight words on B with its consumer always ready.
        for (int i = 0; i <= 8; i++) begin
            drive(i < 8, 1'b1, 16'(i + 1), 1'b0, 1'b1);
            if (i < 8) chk("stream_in_ready", in_ready, 1);
            if (i > 0) begin
                chk("stream_b_valid", b_valid, 1);
                chk("stream_b_data",  b_data,  i);
            end
        end
        drive(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
        chk("stream_b_count", b_count, 8);
        chk("stream_a_count", a_count, 0);
        chk("stream_b_empty", b_valid, 0);

        // Drain and refill of A on the same edge.
        drive(1'b1, 1'b0, 16'hAAAA, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'h5555, 1'b1, 1'b0);
        chk("simul_in_ready", in_ready, 1);
        chk("simul_a_old",    a_data,   16'hAAAA);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("simul_a_valid",  a_valid,  1);
        chk("simul_a_new",    a_data,   16'h5555);
        chk("simul_a_count",  a_count,  1);

        // Saturation: 300 further drains on A.
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'b0, 16'($urandom), 1'b1, 1'b0);
            if (i == 100) chk("sat_mid_count", a_count, 101);
        end
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        chk("sat_a_count", a_count, 8'hFF);
        chk("sat_b_count", b_count, 8);

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic        v, s, ar, br, exp_rdy, acc;
            logic [15:0] d;
            logic        dr[2];
            v  = ($urandom_range(0, 3) != 0);
            s  = 1'($urandom);
            d  = 16'($urandom);
            ar = ($urandom_range(0, 2) != 0);
            br = ($urandom_range(0, 2) != 0);
            drive(v, s, d, ar, br);

            dr[0]   = m_full[0] & ar;
            dr[1]   = m_full[1] & br;
            exp_rdy = !m_full[s] | dr[s];
            acc     = v & exp_rdy;

            chk("rnd_in_ready", in_ready, exp_rdy);
            chk("rnd_a_valid",  a_valid,  m_full[0]);
            chk("rnd_a_data",   a_data,   m_full[0] ? m_word[0] : 16'h0);
            chk("rnd_b_valid",  b_valid,  m_full[1]);
            chk("rnd_b_data",   b_data,   m_full[1] ? m_word[1] : 16'h0);
            chk("rnd_a_count",  a_count,  (m_cnt[0] > 255) ? 255 : m_cnt[0]);
            chk("rnd_b_count",  b_count,  (m_cnt[1] > 255) ? 255 : m_cnt[1]);

            for (int c = 0; c < 2; c++) begin
                if (dr[c]) begin
                    m_cnt[c]++;
                    m_full[c] = 1'b0;
                end
            end
            if (acc) begin
                m_full[s] = 1'b1;
                m_word[s] = d;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
